align_shift_pipe: RTL and testbench

Pipelined, parametrised right-shift aligner for floating-point significands, with guard/round/sticky handling and valid/ready flow control. It sits in the FP add/sub datapath after exponent compare. It right-shifts the smaller operand's extended significand by the exponent difference and folds all shifted-out bits into the sticky bit. It replaces single-cycle combinational alignment: single and double precision share one block, and throughput is one operand per clock.

---
 rtl/align_shift_pipe_pkg.sv | 42 ++++
 rtl/align_shift_pipe_level.sv | 42 ++++
 rtl/align_shift_pipe.sv | 112 +++++++++++
 tb/tb_align_shift_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/align_shift_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : align_shift_pipe_pkg
// Description : Shared FP alignment constants: significand and shift widths
//               for single and double precision, the shift-level count
//               function, and the stage record layouts for both formats.
// Revision    : 1.0 - initial release
// ============================================================================
package align_shift_pipe_pkg;

   // Extended significand (hidden + fraction + G,R,S) and exponent-diff widths
   localparam int SIG_W_SP   = 27;
   localparam int SHIFT_W_SP = 8;
   localparam int SIG_W_DP   = 56;
   localparam int SHIFT_W_DP = 11;
   localparam int TAG_W_DEF  = 4;

   // Number of power-of-two shift levels needed to cover SIG_W-1 positions
   function automatic int align_levels(input int sig_w);
      return $clog2(sig_w);
   endfunction

   localparam int LEVELS_SP = align_levels(SIG_W_SP);
   localparam int LEVELS_DP = align_levels(SIG_W_DP);

   // Stage record: valid, data, remaining shift bits, sideband tag
   typedef struct packed {
      logic                  valid;
      logic [SIG_W_SP-1:0]   sig;
      logic [LEVELS_SP-1:0]  shift;
      logic [TAG_W_DEF-1:0]  tag;
   } align_stage_sp_t;

   typedef struct packed {
      logic                  valid;
      logic [SIG_W_DP-1:0]   sig;
      logic [LEVELS_DP-1:0]  shift;
      logic [TAG_W_DEF-1:0]  tag;
   } align_stage_dp_t;

endpackage
`default_nettype wire

// File: rtl/align_shift_pipe_level.sv
`default_nettype none
// ============================================================================
// Module      : align_shift_level
// Description : One combinational alignment level: right shift by 2^K when
//               shift bit K is set. With ALIGN_STICKY_EN defined, the bits
//               shifted out (including the old bit 0) are ORed into bit 0.
//               The consumed shift bit is cleared on the way out.
// Revision    : 1.0 - initial release
// ============================================================================
module align_shift_level #(
   parameter int SIG_W = 27,
   parameter int L     = 5,
   parameter int K     = 0
) (
   input  logic [SIG_W-1:0] i_sig,
   input  logic [L-1:0]     i_shift,
   output logic [SIG_W-1:0] o_sig,
   output logic [L-1:0]     o_shift
);

   localparam int S = 1 << K;

`ifdef ALIGN_STICKY_EN
   // Positions that fall off the bottom (bit 0 included) when shifting by S
   localparam logic [SIG_W-1:0] LOST_MASK = {SIG_W{1'b1}} >> (SIG_W - S);
`endif

   // Conditional 2^K shift with optional sticky fold into bit 0
   always_comb begin
      o_shift    = i_shift;
      o_shift[K] = 1'b0;
      o_sig      = i_sig;
      if (i_shift[K]) begin
         o_sig = i_sig >> S;
`ifdef ALIGN_STICKY_EN
         o_sig[0] = o_sig[0] | (|(i_sig & LOST_MASK));
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/align_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : align_shift_pipe
// Description : Pipelined right-shift aligner for FP significands. One
//               register per power-of-two shift level, so latency equals
//               $clog2(SIG_W). Global stall: every stage holds while the
//               output beat is not taken. Oversized shifts saturate at entry.
//               Build macro ALIGN_STICKY_EN enables the sticky fold; without
//               it the block is a plain logical right shift.
// Revision    : 1.0 - initial release
// ============================================================================
module align_shift_pipe
   import align_shift_pipe_pkg::*;
#(
   parameter int SIG_W   = SIG_W_SP,
   parameter int SHIFT_W = SHIFT_W_SP,
   parameter int TAG_W   = TAG_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SIG_W-1:0]   in_sig,
   input  logic [SHIFT_W-1:0] in_shift,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SIG_W-1:0]   out_sig,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int L = align_levels(SIG_W);

   typedef struct packed {
      logic              valid;
      logic [SIG_W-1:0]  sig;
      logic [L-1:0]      shift;
      logic [TAG_W-1:0]  tag;
   } stage_t;

   stage_t           stage_q   [L];
   stage_t           stage_d   [L];
   stage_t           lvl_src   [L];
   logic [SIG_W-1:0] lvl_sig   [L];
   logic [L-1:0]     lvl_shift [L];
   logic             w_sat;

   // Stall only when a result is waiting and the consumer refuses it
   assign in_ready  = ~(stage_q[L-1].valid & ~out_ready);

   assign out_valid = stage_q[L-1].valid;
   assign out_sig   = stage_q[L-1].sig;
   assign out_tag   = stage_q[L-1].tag;

   // Entry saturation and per-level source selection
   always_comb begin
      w_sat            = (32'(in_shift) >= 32'(SIG_W));
      lvl_src[0].valid = in_valid;
      lvl_src[0].tag   = in_tag;
      // A saturated beat needs no level shifting: its result is formed here
      lvl_src[0].shift = w_sat ? '0 : in_shift[L-1:0];
`ifdef ALIGN_STICKY_EN
      lvl_src[0].sig   = w_sat ? {{(SIG_W-1){1'b0}}, |in_sig} : in_sig;
`else
      lvl_src[0].sig   = w_sat ? '0 : in_sig;
`endif
      for (int k = 1; k < L; k++) begin
         lvl_src[k] = stage_q[k-1];
      end
   end

   generate
      for (genvar k = 0; k < L; k++) begin : g_level
         align_shift_level #(
            .SIG_W (SIG_W),
            .L     (L),
            .K     (k)
         ) u_level (
            .i_sig   (lvl_src[k].sig),
            .i_shift (lvl_src[k].shift),
            .o_sig   (lvl_sig[k]),
            .o_shift (lvl_shift[k])
         );
      end
   endgenerate

   // Next stage contents: advance everything together, or hold on stall
   always_comb begin
      for (int k = 0; k < L; k++) begin
         stage_d[k] = stage_q[k];
         if (in_ready) begin
            stage_d[k].valid = lvl_src[k].valid;
            stage_d[k].sig   = lvl_sig[k];
            stage_d[k].shift = lvl_shift[k];
            stage_d[k].tag   = lvl_src[k].tag;
         end
      end
   end

   // Stage registers; reset flushes every in-flight beat
   always_ff @(posedge clk) begin
      for (int k = 0; k < L; k++) begin
         if (rst) begin
            stage_q[k] <= '0;
         end else begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_align_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_align_shift_pipe
// Description : Scoreboard bench for align_shift_pipe at single precision.
//               Expected results are queued at input handshake and popped at
//               output handshake; latency is checked for unstalled beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_align_shift_pipe;

   localparam int SIG_W   = 27;
   localparam int SHIFT_W = 8;
   localparam int TAG_W   = 4;
   localparam int LAT     = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [SIG_W-1:0]   in_sig = '0;
   logic [SHIFT_W-1:0] in_shift = '0;
   logic [TAG_W-1:0]   in_tag = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [SIG_W-1:0]   out_sig;
   logic [TAG_W-1:0]   out_tag;

   typedef struct {
      logic [SIG_W-1:0] sig;
      logic [TAG_W-1:0] tag;
      int               cyc;
      int               stalls;
   } exp_t;

   exp_t sb[$];
   int   n_vec     = 0;
   int   n_err     = 0;
   int   cyc       = 0;
   int   stall_cnt = 0;

   align_shift_pipe #(
      .SIG_W   (SIG_W),
      .SHIFT_W (SHIFT_W),
      .TAG_W   (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sig    (in_sig),
      .in_shift  (in_shift),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sig   (out_sig),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: right shift, with lost bits ORed into bit 0 when sticky is on
   function automatic logic [SIG_W-1:0] model(input logic [SIG_W-1:0] s, input logic [SHIFT_W-1:0] sh);
      logic [SIG_W-1:0] r;
      if (sh >= SHIFT_W'(SIG_W)) r = '0;
      else                       r = s >> sh;
`ifdef ALIGN_STICKY_EN
      if (sh >= SHIFT_W'(SIG_W)) r[0] = |s;
      else                       r[0] = r[0] | (|(s & ((27'd1 << sh) - 27'd1)));
`endif
      return r;
   endfunction

   // Scoreboard: handshakes observed at negedge take effect on the next posedge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && !out_ready) stall_cnt++;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_sig", 64'(out_sig), 64'(e.sig));
               check("out_tag", 64'(out_tag), 64'(e.tag));
               if (e.stalls == stall_cnt) check("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{sig: model(in_sig, in_shift), tag: in_tag, cyc: cyc, stalls: stall_cnt});
         end
      end
   end

   task automatic send(input logic [SIG_W-1:0] s, input logic [SHIFT_W-1:0] sh, input logic [TAG_W-1:0] t);
      int guard = 0;
      in_valid = 1'b1;
      in_sig   = s;
      in_shift = sh;
      in_tag   = t;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || out_valid) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      logic [SIG_W-1:0] held_sig;
      logic [TAG_W-1:0] held_tag;

      // Reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_sig",   64'(out_sig),   64'(0));
      check("rst_out_tag",   64'(out_tag),   64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed boundary patterns
      send(27'h4000000, 8'd3,   4'h1);
      send(27'h0000018, 8'd5,   4'h2);
      send(27'h5A5A5A0, 8'd27,  4'h3);
      send(27'h5A5A5A0, 8'd200, 4'h4);
      send(27'h5A5A5A1, 8'd0,   4'h5);
      send(27'h7FFFFFE, 8'd26,  4'h6);
      send(27'h0000001, 8'd26,  4'h7);
      send(27'h3FFFFFF, 8'd26,  4'h8);
      drain();

      // Back-to-back random beats
      for (int i = 0; i < 20; i++) begin
         send(SIG_W'($urandom), SHIFT_W'($urandom_range(0, 31)), TAG_W'(i));
      end
      drain();

      // Output stall held for three cycles while the producer keeps offering
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send(SIG_W'($urandom), SHIFT_W'($urandom_range(0, 28)), TAG_W'(4'h8 + i));
            end
         end
         begin
            int guard = 0;
            @(negedge clk);
            while (!out_valid && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            check("stall_out_valid", 64'(out_valid), 64'(1));
            held_sig = out_sig;
            held_tag = out_tag;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("stall_sig",      64'(out_sig),   64'(held_sig));
               check("stall_tag",      64'(out_tag),   64'(held_tag));
               check("stall_valid",    64'(out_valid), 64'(1));
               check("stall_in_ready", 64'(in_ready),  64'(0));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three beats in flight, plus a beat offered during reset
      send(27'h1234567, 8'd1, 4'hA);
      send(27'h2345678, 8'd2, 4'hB);
      send(27'h3456789, 8'd3, 4'hC);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sig   = 27'h7654321;
      in_shift = 8'd4;
      in_tag   = 4'hD;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_out_sig",   64'(out_sig),   64'(0));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_stale_out", 64'(out_valid), 64'(0));
      end
      send(27'h0ABCDEF, 8'd7, 4'hE);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
